alu_seq: RTL and testbench

Parametrised successor to the team's single-cycle registered ALU. It keeps the same 16-entry alu_fun encoding and adds the following:
- Full-width multiply result (high half).
- Iterative restoring divider with remainder.
- Status flags.
- Input ready handshake for multi-cycle operations.

It sits between the register-file/controller and the result bus and is driven by the system controller FSM.

---
 rtl/alu_seq.sv | 136 +++++++++++++
 tb/tb_alu_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with 16-op encoding, full-width multiply, iterative restoring
// divider (quotient + remainder), status flags and an input-ready handshake.
module alu_seq #(
    parameter int dataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] A,
    input  logic [dataWidth-1:0] B,
    input  logic [3:0]           alu_fun,
    input  logic                 alu_en,
    output logic                 in_ready,
    output logic [dataWidth-1:0] alu_out,
    output logic [dataWidth-1:0] alu_out_hi,
    output logic                 out_valid,
    output logic                 flag_zero,
    output logic                 flag_carry,
    output logic                 flag_div_err,
    output logic                 busy
);
    localparam int W     = dataWidth;
    localparam int CNT_W = $clog2(dataWidth + 1);

    typedef enum logic {IDLE, DIV} state_t;

    state_t         state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]   quo, rem, dvs;

    logic           accept, start_div;
    logic [W-1:0]   res_lo, res_hi;
    logic           res_c, res_e;
    logic [W:0]     sum;
    logic [2*W-1:0] prod;

    logic [W:0]     rem_sh;
    logic           q_bit;
    logic [W-1:0]   rem_nxt, quo_nxt;

    assign in_ready  = (state == IDLE);
    assign busy      = ~in_ready;
    assign accept    = alu_en && in_ready;
    assign start_div = accept && (alu_fun == 4'b0011) && (B != '0);

    // quo starts as the dividend and shifts left; quotient bits fill in from the LSB
    assign rem_sh  = {rem, quo[W-1]};
    assign q_bit   = (rem_sh >= {1'b0, dvs});
    assign rem_nxt = q_bit ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];
    assign quo_nxt = {quo[W-2:0], q_bit};

    assign sum  = {1'b0, A} + {1'b0, B};
    assign prod = {{W{1'b0}}, A} * {{W{1'b0}}, B};

    always_comb begin
        res_lo = '0;
        res_hi = '0;
        res_c  = 1'b0;
        res_e  = 1'b0;
        case (alu_fun)
            4'b0000: begin res_lo = sum[W-1:0]; res_c = sum[W]; end
            4'b0001: begin res_lo = A - B; res_c = (A < B); end
            4'b0010: begin res_lo = prod[W-1:0]; res_hi = prod[2*W-1:W]; res_c = |prod[2*W-1:W]; end
            // only reaches the result registers for a zero divisor
            4'b0011: begin res_lo = '1; res_hi = A; res_e = 1'b1; end
            4'b0100: res_lo = A & B;
            4'b0101: res_lo = A | B;
            4'b0110: res_lo = ~(A & B);
            4'b0111: res_lo = ~(A | B);
            4'b1000: res_lo = A ^ B;
            4'b1001: res_lo = ~(A ^ B);
            4'b1010: res_lo = (A == B) ? W'(1) : '0;
            4'b1011: res_lo = (A > B)  ? W'(2) : '0;
            4'b1100: res_lo = (A < B)  ? W'(3) : '0;
            4'b1101: begin res_lo = A >> 1; res_c = A[0]; end
            4'b1110: begin res_lo = A << 1; res_c = A[W-1]; end
            default: res_lo = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_div) state_nxt = DIV;
            DIV:     if (cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            quo          <= '0;
            rem          <= '0;
            dvs          <= '0;
            alu_out      <= '0;
            alu_out_hi   <= '0;
            out_valid    <= 1'b0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            flag_div_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start_div) begin
                quo <= A;
                dvs <= B;
                rem <= '0;
                cnt <= CNT_W'(W);
            end else if (accept) begin
                alu_out      <= res_lo;
                alu_out_hi   <= res_hi;
                flag_zero    <= (res_lo == '0);
                flag_carry   <= res_c;
                flag_div_err <= res_e;
                out_valid    <= 1'b1;
            end
            if (state == DIV) begin
                quo <= quo_nxt;
                rem <= rem_nxt;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    alu_out      <= quo_nxt;
                    alu_out_hi   <= rem_nxt;
                    flag_zero    <= (quo_nxt == '0);
                    flag_carry   <= 1'b0;
                    flag_div_err <= 1'b0;
                    out_valid    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected results, a negedge
// monitor pops and compares on every out_valid, including result timing.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic [3:0]   alu_fun = '0;
    logic         alu_en = 1'b0;
    logic         in_ready, out_valid, flag_zero, flag_carry, flag_div_err, busy;
    logic [W-1:0] alu_out, alu_out_hi;

    alu_seq #(.dataWidth(W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .alu_fun(alu_fun), .alu_en(alu_en),
        .in_ready(in_ready), .alu_out(alu_out), .alu_out_hi(alu_out_hi),
        .out_valid(out_valid), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_div_err(flag_div_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z, c, e;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour from plain integer arithmetic
    function automatic exp_t model(input logic [3:0] f, input longint unsigned a, input longint unsigned b);
        exp_t x;
        longint unsigned m = (64'd1 << W) - 1;
        longint unsigned r = 0, h = 0;
        x.c = 1'b0;
        x.e = 1'b0;
        case (f)
            4'd0:  begin r = a + b; x.c = ((a + b) >> W) != 0; end
            4'd1:  begin r = a - b; x.c = (a < b); end
            4'd2:  begin r = a * b; h = (a * b) >> W; x.c = (h != 0); end
            4'd3:  if (b == 0) begin r = m; h = a; x.e = 1'b1; end
                   else begin r = a / b; h = a % b; end
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = ~(a & b);
            4'd7:  r = ~(a | b);
            4'd8:  r = a ^ b;
            4'd9:  r = ~(a ^ b);
            4'd10: r = (a == b) ? 1 : 0;
            4'd11: r = (a > b) ? 2 : 0;
            4'd12: r = (a < b) ? 3 : 0;
            4'd13: begin r = a >> 1; x.c = a[0]; end
            4'd14: begin r = a << 1; x.c = ((a >> (W - 1)) & 1) != 0; end
            default: r = 0;
        endcase
        x.lo  = W'(r & m);
        x.hi  = W'(h & m);
        x.z   = ((r & m) == 0);
        x.cyc = 0;
        return x;
    endfunction

    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("result_cycle", cyc, x.cyc);
                chk("alu_out", alu_out, x.lo);
                chk("alu_out_hi", alu_out_hi, x.hi);
                chk("flag_zero", flag_zero, x.z);
                chk("flag_carry", flag_carry, x.c);
                chk("flag_div_err", flag_div_err, x.e);
            end
        end
    end

    // Waits (bounded) for in_ready, drives one op for one edge, pushes its expectation
    task automatic op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        alu_en = 1'b1; alu_fun = f; A = a; B = b;
        x = model(f, a, b);
        x.cyc = cyc + 1 + ((f == 4'd3 && b != 0) ? W : 0);
        sb.push_back(x);
        @(posedge clk); #1;
        alu_en = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alu_out"}, alu_out, 0);
        chk({tag, "_alu_out_hi"}, alu_out_hi, 0);
        chk({tag, "_flags"}, {flag_zero, flag_carry, flag_div_err}, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    function automatic logic [3:0] rand_nondiv();
        logic [3:0] f;
        f = 4'($urandom_range(0, 15));
        if (f == 4'd3) f = 4'd8;
        return f;
    endfunction

    initial begin
        #12;
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        op(4'd0, 8'd200, 8'd100);
        op(4'd1, 8'd5, 8'd7);
        op(4'd2, 8'd20, 8'd30);
        op(4'd2, 8'd15, 8'd17);

        // Divide with busy-window noise on alu_en and operands
        op(4'd3, 8'd200, 8'd7);
        for (int i = 0; i < W; i++) begin
            chk("div_in_ready_low", in_ready, 0);
            chk("div_busy", busy, 1);
            alu_en = 1'b1; alu_fun = rand_nondiv();
            A = 8'($urandom); B = 8'($urandom);
            @(posedge clk); #1;
        end
        alu_en = 1'b0;
        chk("div_done_in_ready", in_ready, 1);

        op(4'd3, 8'd9, 8'd0);
        op(4'd8, 8'hF0, 8'hFF);

        // Back-to-back: every non-divide op, A=0x81 exercises shift carries
        for (int i = 0; i < 16; i++) begin
            logic [3:0] f;
            f = 4'(i);
            if (f == 4'd3) f = 4'd10;
            op(f, 8'h81, (i % 2 == 0) ? 8'h81 : 8'($urandom));
        end
        op(4'd11, 8'd9, 8'd4);
        op(4'd12, 8'd4, 8'd9);
        op(4'd10, 8'd4, 8'd9);

        // Randomized mix including divides and zero divisors
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] b;
            b = ($urandom_range(0, 9) == 0) ? '0 : 8'($urandom);
            op(4'($urandom_range(0, 15)), 8'($urandom), b);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        while (!in_ready) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        // Reset in the 4th divide cycle aborts with no result
        op(4'd3, 8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        chk_reset_outputs("mid_div_reset");
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        op(4'd3, 8'd100, 8'd10);
        repeat (W + 3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
